// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the backing-memory arbiter: default widths, state encodings
// and the round-robin tie-break helper.
package mem_arbiter_pkg;

  localparam int DMEM_BLOCK_ADDR_SIZE = 26;
  localparam int DBLOCK_SIZE_BITS     = 128;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_I_READ  = 3'd1;
  localparam logic [2:0] ST_D_READ  = 3'd2;
  localparam logic [2:0] ST_D_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grantSide_t;

  // I wins when it is alone, or on a tie when D was the last side served.
  function automatic logic pickI(input logic iReq, input logic dReq, input grantSide_t lastGrant);
    return iReq && (!dReq || (lastGrant == GRANT_D));
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between the I-cache and
// D-cache controllers; one transaction in flight, registered responses.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | no transaction; sample requests, grant and latch address/data
//   ST_I_READ  | mem_ren held for the I-side refill until mem_read_ready
//   ST_D_READ  | mem_ren held for the D-side refill until mem_read_ready
//   ST_D_WRITE | mem_wen held for the D-side write-back until mem_write_done
//   ST_RESP    | single response pulse to the requester; requests ignored
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_W = DBLOCK_SIZE_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_ren,
  input  logic [ADDR_W-1:0]  i_block_address,
  output logic [BLOCK_W-1:0] i_dout,
  output logic               i_read_ready,
  input  logic               d_ren,
  input  logic               d_wen,
  input  logic [ADDR_W-1:0]  d_block_address,
  input  logic [BLOCK_W-1:0] d_din,
  output logic [BLOCK_W-1:0] d_dout,
  output logic               d_read_ready,
  output logic               d_write_done,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_block_address,
  output logic [BLOCK_W-1:0] mem_din,
  input  logic [BLOCK_W-1:0] mem_dout,
  input  logic               mem_read_ready,
  input  logic               mem_write_done,
  output logic               busy
);

  logic [2:0] state;
  grantSide_t lastGrant;
  logic       dReq;
  logic       grantI;
  logic       grantD;
  logic       inIdle;

  assign dReq   = d_ren | d_wen;
  assign inIdle = (state == ST_IDLE);
  assign grantI = inIdle && pickI(i_ren, dReq, lastGrant);
  assign grantD = inIdle && dReq && !pickI(i_ren, dReq, lastGrant);
  assign busy   = !inIdle;

  // FSM, grant bookkeeping, memory strobes and response pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      lastGrant    <= GRANT_D;
      mem_ren      <= 1'b0;
      mem_wen      <= 1'b0;
      i_read_ready <= 1'b0;
      d_read_ready <= 1'b0;
      d_write_done <= 1'b0;
    end else begin
      i_read_ready <= 1'b0;
      d_read_ready <= 1'b0;
      d_write_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grantI) begin
            state     <= ST_I_READ;
            mem_ren   <= 1'b1;
            lastGrant <= GRANT_I;
          end else if (grantD) begin
            lastGrant <= GRANT_D;
            // A simultaneous read+write from D is treated as the write-back.
            if (d_wen) begin
              state   <= ST_D_WRITE;
              mem_wen <= 1'b1;
            end else begin
              state   <= ST_D_READ;
              mem_ren <= 1'b1;
            end
          end
        end
        ST_I_READ: begin
          if (mem_read_ready) begin
            mem_ren      <= 1'b0;
            i_read_ready <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_D_READ: begin
          if (mem_read_ready) begin
            mem_ren      <= 1'b0;
            d_read_ready <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_D_WRITE: begin
          if (mem_write_done) begin
            mem_wen      <= 1'b0;
            d_write_done <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
        end
      endcase
    end
  end

  // Latched request copy drives memory; response data holds until the next capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_block_address <= '0;
      mem_din           <= '0;
      i_dout            <= '0;
      d_dout            <= '0;
    end else begin
      if (grantI) begin
        mem_block_address <= i_block_address;
      end else if (grantD) begin
        mem_block_address <= d_block_address;
        if (d_wen) mem_din <= d_din;
      end
      if ((state == ST_I_READ) && mem_read_ready) i_dout <= mem_dout;
      if ((state == ST_D_READ) && mem_read_ready) d_dout <= mem_dout;
    end
  end

endmodule
